// File: rtl/aon_pkg.sv
// Shared types and default timing for the always-on power-management unit.
package aon_pkg;

    localparam int unsigned ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        StRun,
        StIsoOn,
        StSleep,
        StPwrUp,
        StIsoOff
    } pmu_state_e;

    localparam int unsigned DEF_DLY_ISO = 4;
    localparam int unsigned DEF_DLY_PWR = 16;

endpackage

// File: rtl/aon_sync.sv
// Two-flop synchroniser for asynchronous level inputs into the always-on clock domain.
module aon_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aon_pmu.sv
// Always-on PMU: free-running RTC with sticky alarm, plus a sleep sequencer that orders
// isolation and power-down of switchable domains and restores them on a wake event.
module aon_pmu
    import aon_pkg::*;
#(
    parameter int unsigned RTC_W   = 48,
    parameter int unsigned N_PD    = 2,
    parameter int unsigned N_WAKE  = 4,
    parameter int unsigned DLY_ISO = DEF_DLY_ISO,
    parameter int unsigned DLY_PWR = DEF_DLY_PWR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rtc_en,
    input  logic              rtc_ld,
    input  logic [RTC_W-1:0]  rtc_ld_val,
    output logic [RTC_W-1:0]  rtc,
    input  logic              alarm_en,
    input  logic [RTC_W-1:0]  alarm_val,
    input  logic              alarm_clr,
    output logic              alarm_irq,
    input  logic              sleep_req,
    input  logic [N_PD-1:0]   pd_mask,
    input  logic [N_WAKE-1:0] wake_ext,
    input  logic [N_WAKE-1:0] wake_mask,
    output logic [N_PD-1:0]   pd,
    output logic [N_PD-1:0]   iso,
    output logic              ready,
    output logic              sleeping,
    output logic [N_WAKE:0]   wake_cause
);

    localparam int unsigned DLY_MAX = (DLY_ISO > DLY_PWR) ? DLY_ISO : DLY_PWR;
    localparam int unsigned CNT_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_ISO = CNT_W'(DLY_ISO - 1);
    localparam logic [CNT_W-1:0] CNT_PWR = CNT_W'(DLY_PWR - 1);

    pmu_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [N_PD-1:0]   msk;
    logic [N_WAKE-1:0] wake_s;
    logic              match;
    logic [N_WAKE:0]   cause_now;
    logic              any_wake;

    aon_sync #(
        .W (N_WAKE)
    ) u_wake_sync (
        .clk (clk),
        .rst (rst),
        .d   (wake_ext),
        .q   (wake_s)
    );

    assign match     = alarm_en && (rtc == alarm_val);
    assign cause_now = {match, wake_s & wake_mask};
    assign any_wake  = |cause_now;
    assign ready     = (state == StRun);
    assign sleeping  = (state == StSleep);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rtc       <= '0;
            alarm_irq <= 1'b0;
        end else begin
            if (rtc_ld) begin
                rtc <= rtc_ld_val;
            end else if (rtc_en) begin
                rtc <= rtc + RTC_W'(1);
            end
            // A fresh match outranks a simultaneous clear so no alarm is lost.
            if (match) begin
                alarm_irq <= 1'b1;
            end else if (alarm_clr) begin
                alarm_irq <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StRun;
            cnt        <= '0;
            msk        <= '0;
            pd         <= '0;
            iso        <= '0;
            wake_cause <= '0;
        end else begin
            case (state)
                StRun: begin
                    if (sleep_req && (pd_mask != '0)) begin
                        msk        <= pd_mask;
                        iso        <= pd_mask;
                        wake_cause <= '0;
                        cnt        <= CNT_ISO;
                        state      <= StIsoOn;
                    end
                end
                StIsoOn: begin
                    // A wake that lands while isolating aborts before any domain loses power.
                    if (any_wake) begin
                        wake_cause <= cause_now;
                        iso        <= '0;
                        cnt        <= CNT_ISO;
                        state      <= StIsoOff;
                    end else if (cnt == '0) begin
                        pd    <= msk;
                        state <= StSleep;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                StSleep: begin
                    if (any_wake) begin
                        wake_cause <= cause_now;
                        pd         <= '0;
                        cnt        <= CNT_PWR;
                        state      <= StPwrUp;
                    end
                end
                StPwrUp: begin
                    if (cnt == '0) begin
                        iso   <= '0;
                        cnt   <= CNT_ISO;
                        state <= StIsoOff;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                StIsoOff: begin
                    if (cnt == '0) begin
                        state <= StRun;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_aon_pmu.sv
// Randomised and directed bench for aon_pmu against a deadline-based behavioural model.
module tb_aon_pmu;

    localparam int unsigned RTC_W   = 48;
    localparam int unsigned N_PD    = 2;
    localparam int unsigned N_WAKE  = 4;
    localparam int unsigned DLY_ISO = 4;
    localparam int unsigned DLY_PWR = 16;

    localparam int P_AWAKE  = 0;
    localparam int P_DOWN   = 1;
    localparam int P_ASLEEP = 2;
    localparam int P_UP     = 3;
    localparam int P_SETTLE = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rtc_en;
    logic              rtc_ld;
    logic [RTC_W-1:0]  rtc_ld_val;
    logic [RTC_W-1:0]  rtc;
    logic              alarm_en;
    logic [RTC_W-1:0]  alarm_val;
    logic              alarm_clr;
    logic              alarm_irq;
    logic              sleep_req;
    logic [N_PD-1:0]   pd_mask;
    logic [N_WAKE-1:0] wake_ext;
    logic [N_WAKE-1:0] wake_mask;
    logic [N_PD-1:0]   pd;
    logic [N_PD-1:0]   iso;
    logic              ready;
    logic              sleeping;
    logic [N_WAKE:0]   wake_cause;

    always #5 clk = ~clk;

    aon_pmu #(
        .RTC_W   (RTC_W),
        .N_PD    (N_PD),
        .N_WAKE  (N_WAKE),
        .DLY_ISO (DLY_ISO),
        .DLY_PWR (DLY_PWR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rtc_en     (rtc_en),
        .rtc_ld     (rtc_ld),
        .rtc_ld_val (rtc_ld_val),
        .rtc        (rtc),
        .alarm_en   (alarm_en),
        .alarm_val  (alarm_val),
        .alarm_clr  (alarm_clr),
        .alarm_irq  (alarm_irq),
        .sleep_req  (sleep_req),
        .pd_mask    (pd_mask),
        .wake_ext   (wake_ext),
        .wake_mask  (wake_mask),
        .pd         (pd),
        .iso        (iso),
        .ready      (ready),
        .sleeping   (sleeping),
        .wake_cause (wake_cause)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: RTC as plain arithmetic, sequencer as phases with absolute deadlines.
    logic [RTC_W-1:0]  m_rtc;
    logic              m_irq;
    logic [N_WAKE-1:0] m_hist1, m_hist2;
    int                m_phase;
    longint            m_edge, m_due;
    logic [N_PD-1:0]   m_pd, m_iso, m_msk;
    logic [N_WAKE:0]   m_cause;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rtc = '0; m_irq = 1'b0; m_hist1 = '0; m_hist2 = '0;
        m_phase = P_AWAKE; m_edge = 0; m_due = 0;
        m_pd = '0; m_iso = '0; m_msk = '0; m_cause = '0;
    endtask

    task automatic model_step();
        logic            hit;
        logic [N_WAKE:0] cause;
        if (rst) begin
            model_reset();
            return;
        end
        hit   = alarm_en && (m_rtc == alarm_val);
        cause = {hit, m_hist2 & wake_mask};
        m_edge++;
        if (m_phase == P_AWAKE) begin
            if (sleep_req && pd_mask != 0) begin
                m_msk = pd_mask; m_iso = pd_mask; m_cause = '0;
                m_phase = P_DOWN; m_due = m_edge + DLY_ISO;
            end
        end else if (m_phase == P_DOWN) begin
            if (cause != 0) begin
                m_cause = cause; m_iso = '0;
                m_phase = P_SETTLE; m_due = m_edge + DLY_ISO;
            end else if (m_edge == m_due) begin
                m_pd = m_msk; m_phase = P_ASLEEP;
            end
        end else if (m_phase == P_ASLEEP) begin
            if (cause != 0) begin
                m_cause = cause; m_pd = '0;
                m_phase = P_UP; m_due = m_edge + DLY_PWR;
            end
        end else if (m_phase == P_UP) begin
            if (m_edge == m_due) begin
                m_iso = '0; m_phase = P_SETTLE; m_due = m_edge + DLY_ISO;
            end
        end else if (m_edge == m_due) begin
            m_phase = P_AWAKE;
        end
        if (hit) m_irq = 1'b1;
        else if (alarm_clr) m_irq = 1'b0;
        if (rtc_ld) m_rtc = rtc_ld_val;
        else if (rtc_en) m_rtc = m_rtc + 48'd1;
        m_hist2 = m_hist1;
        m_hist1 = wake_ext;
    endtask

    task automatic check_all();
        check_eq("rtc", 64'(rtc), 64'(m_rtc));
        check_eq("alarm_irq", 64'(alarm_irq), 64'(m_irq));
        check_eq("pd", 64'(pd), 64'(m_pd));
        check_eq("iso", 64'(iso), 64'(m_iso));
        check_eq("ready", 64'(ready), 64'(m_phase == P_AWAKE));
        check_eq("sleeping", 64'(sleeping), 64'(m_phase == P_ASLEEP));
        check_eq("wake_cause", 64'(wake_cause), 64'(m_cause));
        check_eq("pd_implies_iso", 64'(pd & ~iso), 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_phase(input int phase, input int budget, input string tag);
        int k = 0;
        while (m_phase != phase && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 64'(m_phase == phase), 64'd1);
    endtask

    task automatic pulse_sleep(input logic [N_PD-1:0] m);
        pd_mask = m; sleep_req = 1'b1;
        tick();
        sleep_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rtc_en = 0; rtc_ld = 0; rtc_ld_val = '0; alarm_en = 0; alarm_val = '0;
        alarm_clr = 0; sleep_req = 0; pd_mask = '0; wake_ext = '0; wake_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1'b0;

        // RTC count, load and wrap.
        rtc_en = 1'b1;
        repeat (10) tick();
        check_eq("rtc_after_10", 64'(rtc), 64'd10);
        rtc_ld = 1'b1; rtc_ld_val = 48'hFFFF_FFFF_FFFE;
        tick();
        rtc_ld = 1'b0;
        check_eq("rtc_loaded", 64'(rtc), 64'hFFFF_FFFF_FFFE);
        tick();
        check_eq("rtc_all_ones", 64'(rtc), 64'hFFFF_FFFF_FFFF);
        tick();
        check_eq("rtc_wrap", 64'(rtc), 64'd0);

        // Alarm: set wins over a clear on the match cycle, clear alone drops it.
        rtc_ld = 1'b1; rtc_ld_val = '0;
        tick();
        rtc_ld = 1'b0; alarm_val = 48'd5; alarm_en = 1'b1;
        for (int k = 0; k < 20 && m_rtc != 48'd5; k++) tick();
        check_eq("alarm_reach5", 64'(rtc), 64'd5);
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
        check_eq("irq_set_wins", 64'(alarm_irq), 64'd1);
        repeat (2) tick();
        alarm_en = 1'b0; alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
        check_eq("irq_cleared", 64'(alarm_irq), 64'd0);

        // Full sleep and external wake with exact timing.
        wake_mask = 4'b0100;
        pulse_sleep(2'b11);
        check_eq("iso_t1", 64'(iso), 64'h3);
        repeat (3) tick();
        check_eq("pd_t4", 64'(pd), 64'h0);
        tick();
        check_eq("pd_t5", 64'(pd), 64'h3);
        check_eq("sleeping_t5", 64'(sleeping), 64'd1);
        repeat (5) tick();
        wake_ext = 4'b0100;
        repeat (2) tick();
        check_eq("pd_w2", 64'(pd), 64'h3);
        tick();
        check_eq("pd_w3", 64'(pd), 64'h0);
        repeat (15) tick();
        check_eq("iso_w18", 64'(iso), 64'h3);
        tick();
        check_eq("iso_w19", 64'(iso), 64'h0);
        repeat (3) tick();
        check_eq("ready_w22", 64'(ready), 64'd0);
        tick();
        check_eq("ready_w23", 64'(ready), 64'd1);
        check_eq("cause_ext2", 64'(wake_cause), 64'h04);
        wake_ext = '0;
        repeat (3) tick();

        // Isolation-only abort: wake arrives before power-down.
        pulse_sleep(2'b01);
        tick();
        wake_ext = 4'b0100;
        wait_phase(P_AWAKE, 40, "abort_to_run");
        check_eq("abort_cause", 64'(wake_cause), 64'h04);
        check_eq("abort_iso", 64'(iso), 64'h0);
        wake_ext = '0;
        repeat (3) tick();

        // Alarm wake; masked external activity must not wake.
        pulse_sleep(2'b11);
        wait_phase(P_ASLEEP, 20, "alarm_sleep_entry");
        for (int k = 0; k < 6; k++) begin
            wake_ext = 4'($urandom) & 4'b1011;
            tick();
        end
        wake_ext = '0;
        repeat (2) tick();
        check_eq("masked_keeps_sleep", 64'(sleeping), 64'd1);
        alarm_val = m_rtc + 48'd3; alarm_en = 1'b1;
        repeat (3) tick();
        check_eq("pd_before_match", 64'(pd), 64'h3);
        tick();
        check_eq("pd_after_match", 64'(pd), 64'h0);
        check_eq("cause_alarm", 64'(wake_cause), 64'h10);
        alarm_en = 1'b0;
        wait_phase(P_AWAKE, 40, "alarm_wake_run");
        alarm_clr = 1'b1;
        pulse_sleep(2'b00);
        alarm_clr = 1'b0;
        check_eq("zero_mask_ignored", 64'(ready), 64'd1);
        tick();

        // Randomised traffic.
        for (int k = 0; k < 800; k++) begin
            rtc_en    = ($urandom_range(0, 7) != 0);
            rtc_ld    = ($urandom_range(0, 49) == 0);
            rtc_ld_val = 48'({$urandom(), $urandom()});
            if ($urandom_range(0, 9) == 0) alarm_val = m_rtc + 48'($urandom_range(0, 20));
            alarm_en  = ($urandom_range(0, 2) == 0);
            alarm_clr = ($urandom_range(0, 7) == 0);
            sleep_req = ($urandom_range(0, 14) == 0);
            pd_mask   = 2'($urandom);
            if ($urandom_range(0, 29) == 0) wake_mask = 4'($urandom);
            if ($urandom_range(0, 11) == 0) wake_ext = 4'($urandom);
            tick();
        end
        rtc_ld = 0; alarm_en = 0; alarm_clr = 0; sleep_req = 0; wake_ext = '0;
        wait_phase(P_AWAKE, 60, "random_settle");

        // Asynchronous reset during power-up.
        wake_mask = 4'b0001;
        repeat (3) tick();
        pulse_sleep(2'b11);
        wait_phase(P_ASLEEP, 20, "rst_sleep_entry");
        wake_ext = 4'b0001;
        wait_phase(P_UP, 10, "rst_reach_pwrup");
        repeat (3) tick();
        wake_ext = '0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check_eq("rst_pd", 64'(pd), 64'h0);
        check_eq("rst_iso", 64'(iso), 64'h0);
        check_eq("rst_ready", 64'(ready), 64'd1);
        tick();
        rst = 1'b0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aon_pmu.md
Name: aon_pmu

Overview:
- Parametrised always-on power-management unit: free-running synchronous RTC, alarm compare, and a sequencer that powers down and restores up to N_PD switchable domains.
- Sequencer drives isolation and power-down outputs in the correct order with programmable settle delays.
- Sits in the always-on domain on the 32768 Hz clock. Replaces fixed-zero pd_sys/pd_io and the ripple RTC with a wake-capable controller.

Parameters:
- RTC_W, 48, RTC counter and alarm width.
- N_PD, 2, number of switchable power domains (bit 0 = sys, bit 1 = io).
- N_WAKE, 4, number of external asynchronous wake inputs.
- DLY_ISO, 4, cycles between isolation change and the next step; must be ≥1.
- DLY_PWR, 16, cycles from power-up to isolation release; must be ≥1.

Ports:
- clk  in  1  always-on clock (32768 Hz)
- rst  in  1  asynchronous, active-high reset
- rtc_en  in  1  RTC count enable
- rtc_ld  in  1  load RTC from rtc_ld_val
- rtc_ld_val  in  RTC_W  RTC load value
- rtc  out  RTC_W  RTC count
- alarm_en  in  1  alarm compare enable
- alarm_val  in  RTC_W  alarm compare value
- alarm_clr  in  1  clear alarm_irq
- alarm_irq  out  1  sticky alarm flag
- sleep_req  in  1  single-cycle sleep request
- pd_mask  in  N_PD  domains to power down on sleep_req
- wake_ext  in  N_WAKE  asynchronous level wake sources
- wake_mask  in  N_WAKE  wake source enables
- pd  out  N_PD  1 = domain powered down
- iso  out  N_PD  1 = domain outputs isolated
- ready  out  1  sequencer in RUN
- sleeping  out  1  sequencer in SLEEP
- wake_cause  out  N_WAKE+1  bit N_WAKE = alarm, bits below = external sources

Behaviour:
- Reset values: rtc=0, alarm_irq=0, pd=0, iso=0, ready=1, sleeping=0, wake_cause=0, state RUN, sync flops=0. Reset mid-sequence returns immediately to these values (all domains on and de-isolated).
- RTC:
  - Per cycle: if rtc_ld then rtc<=rtc_ld_val (load wins over count); else if rtc_en then rtc<=rtc+1.
  - Wraps from all-ones to 0.
  - Counts in every sequencer state.
- Alarm:
  - match = alarm_en && (rtc==alarm_val), combinational on current rtc.
  - alarm_irq set on the cycle after match. alarm_clr clears it. Set wins when match and alarm_clr occur together.
- Wake sync: wake_ext passes through a 2-flop synchroniser; wake_s is the synchronised value. ext_wake = |(wake_s & wake_mask). any_wake = ext_wake || match.
- Sequencer states RUN, ISO_ON, SLEEP, PWR_UP, ISO_OFF. A down-counter cnt is loaded on each state entry.
  - RUN: ready=1. On sleep_req && pd_mask!=0: latch msk<=pd_mask, clear wake_cause, iso<=msk, go ISO_ON with cnt=DLY_ISO-1. sleep_req with pd_mask==0 is ignored.
  - ISO_ON: when cnt==0: pd<=msk, go SLEEP. If any_wake occurs first, abort: pd is never asserted, record wake_cause, go ISO_OFF with cnt=DLY_ISO-1.
  - SLEEP: sleeping=1. On any_wake: wake_cause<={match, wake_s & wake_mask}, pd<=0, go PWR_UP with cnt=DLY_PWR-1.
  - PWR_UP: when cnt==0: iso<=0, go ISO_OFF with cnt=DLY_ISO-1.
  - ISO_OFF: when cnt==0, go RUN.
  - sleep_req outside RUN is ignored. wake events outside ISO_ON and SLEEP are ignored.
- Timing:
  - sleep_req in cycle T gives iso=msk at T+1 and pd=msk at T+1+DLY_ISO.
  - wake_ext rising in cycle W gives pd=0 at W+3, iso=0 at W+3+DLY_PWR, ready=1 at W+3+DLY_PWR+DLY_ISO.
  - An alarm match in SLEEP at cycle M gives pd=0 at M+1.
- Invariant: for every domain, pd=1 implies iso=1.

Decomposition:
- Package aon_pkg: state enum (RUN, ISO_ON, SLEEP, PWR_UP, ISO_OFF), state width, default delay constants.
- Sub-module aon_sync: parametrised-width 2-flop synchroniser with asynchronous active-high reset, instantiated for wake_ext.

Test Plan:
- Reset, rtc_en=1 for 10 cycles, then rtc_ld with value 0xFFFF_FFFF_FFFE (RTC_W=48) -> rtc=10, then 0xFFFF_FFFF_FFFE, 0xFFFF_FFFF_FFFF, 0 (wrap).
- alarm_val=5, alarm_en=1, count from 0 -> alarm_irq=1 the cycle after rtc==5. alarm_clr on that same match cycle -> alarm_irq stays 1. alarm_clr alone later -> 0.
- sleep_req with pd_mask=2'b11 at T, DLY_ISO=4 -> iso=11 at T+1, pd=11 at T+5, sleeping=1. wake_ext[2] rising at W with wake_mask=4'b0100 -> pd=00 at W+3, iso=00 at W+19, ready at W+23, wake_cause=5'b00100.
- pd_mask=2'b01 with wake_ext[2] high at T+2 -> isolation-only abort: pd never asserts, iso returns to 00, RUN reached, wake_cause=5'b00100.
- Alarm wake: in SLEEP, alarm_val=rtc+3 -> pd=00 the cycle after match, wake_cause=5'b10000. Masked wake_ext toggling keeps SLEEP. sleep_req with pd_mask=0 is ignored.
- Assert rst during PWR_UP -> pd=0, iso=0, ready=1 immediately. The bench checks the pd→iso invariant in every cycle of all scenarios.
